mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the RV32 pipeline. It sits between execute and `wb_stage`. It accepts one execute result at a time and performs loads and stores over a request/grant/response data-bus port. It sign- or zero-extends and aligns load data, detects misaligned accesses and bus errors, and delivers one registered result per instruction on the `rd_*` writeback interface.

## Interface
Parameters:
- `DATA_W`, default 32 (`rv32_pkg`): datapath width.
- `RF_ADDR_WIDTH`, default 5 (`rv32_pkg`): register address width.

Ports:
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `ex_valid_i` in 1: an execute result is offered.
- `ex_ready_o` out 1: the stage accepts the offer. High only in `MEM_IDLE`.
- `ex_alu_result_i` in DATA_W: ALU result, or the effective address for loads and stores.
- `ex_store_data_i` in DATA_W: store data, LSB-aligned.
- `ex_rd_addr_i` in RF_ADDR_WIDTH: destination register.
- `ex_rd_we_i` in 1: the instruction writes `rd`.
- `ex_mem_op_i` in 2: `mem_op_e`, one of NONE, LOAD, STORE.
- `ex_mem_size_i` in 2: `mem_size_e`, one of BYTE, HALF, WORD.
- `ex_mem_unsigned_i` in 1: selects LBU/LHU zero-extension.
- `flush_i` in 1: pipeline flush, driven by `wb_stage` `pipeline_flush_o`.
- `dmem_req_o` out 1: bus request.
- `dmem_gnt_i` in 1: bus grant.
- `dmem_addr_o` out DATA_W: word-aligned address, with `[1:0]` = 0.
- `dmem_we_o` out 1: 1 = store.
- `dmem_be_o` out 4: byte enables.
- `dmem_wdata_o` out DATA_W: store data, lane-shifted.
- `dmem_rvalid_i` in 1: response valid.
- `dmem_rdata_i` in DATA_W: read data.
- `dmem_err_i` in 1: bus error. Qualified by `dmem_rvalid_i`.
- `rd_addr_o` out RF_ADDR_WIDTH: writeback register.
- `rd_data_o` out DATA_W: writeback data, or the mcause code when `rd_exception_o` = 1.
- `rd_valid_o` out 1: one-cycle pulse per retired instruction.
- `rd_exception_o` out 1: the instruction raised an exception.
- `mem_stall_o` out 1: high whenever the stage is not in `MEM_IDLE`.

## Operation
States (`mem_state_e`):
- **`MEM_IDLE`**: on `ex_valid_i && !flush_i`, capture all `ex_*` inputs.
  - NONE: go to `MEM_RESP`.
  - Misaligned access (HALF with `addr[0]`=1, or WORD with `addr[1:0]`≠0): go to `MEM_RESP`, raise the exception, issue no bus request.
  - Aligned LOAD or STORE: go to `MEM_REQ`.
- **`MEM_REQ`**: `dmem_req_o`=1, with address, we, be and wdata held stable. On `dmem_gnt_i`, go to `MEM_WAIT`. On `flush_i` before the grant, drop the request and return to `MEM_IDLE`. The grant wins if it coincides with the flush, and the transfer then continues as flushed.
- **`MEM_WAIT`**: wait for `dmem_rvalid_i`, then go to `MEM_RESP`. If `flush_i` arrived in `MEM_WAIT`, or with the grant, set `drop` and go to `MEM_IDLE` on `rvalid`. A flushed access never produces `rd_valid_o`. Both loads and stores wait for a response.
- **`MEM_RESP`**: pulse `rd_valid_o` for one cycle, then return to `MEM_IDLE`. If `flush_i` is high in this cycle, suppress the pulse.

Data rules:
- Store byte enables:
  - BYTE: `be` = 1 shifted left by `addr[1:0]`, with wdata replicated `{4{b}}`.
  - HALF: `be` = `0011` or `1100`, with wdata `{2{h}}`.
  - WORD: `be` = `1111`.
- Load data: extract the lane given by `addr[1:0]`, then sign-extend. Zero-extend instead when `ex_mem_unsigned_i` = 1.
- `rd_addr_o` is forced to 0 for stores, for `ex_rd_we_i`=0, and for exceptions, so that `wb_stage` never writes the register file.
- Exception codes in `rd_data_o`:
  - load misaligned: 4
  - load access fault (`dmem_err_i`): 5
  - store misaligned: 6
  - store access fault: 7
- Reset mid-access abandons the transaction immediately. The bus owner is reset by the same `rst_ni`.

## Timing
- Reset values: all outputs 0, state `MEM_IDLE`, `drop` = 0. `ex_ready_o` is 1 immediately after reset.
- NONE or misaligned, accepted at edge T: `rd_valid_o` is high in the cycle after edge T+1, giving a 2-cycle accept-to-retire latency.
- Memory op, accepted at edge T:
  - `dmem_req_o` goes high after T.
  - With grant at edge G and rvalid at edge R > G, `rd_valid_o` is high in the cycle after R+1.
  - Zero-wait bus (gnt in the first cycle of `MEM_REQ`, rvalid in the first cycle of `MEM_WAIT`): 4 cycles accept-to-retire.
- A response is never accepted in the same cycle as its grant.
- `rd_*` outputs are registered and stable only while `rd_valid_o`=1.

## Structure
- Add to `rv32_pkg`:
  - `mem_op_e`
  - `mem_size_e`
  - `mem_state_e`
  - `EXC_LOAD_MISALIGNED`
  - `EXC_LOAD_ACCESS_FAULT`
  - `EXC_STORE_MISALIGNED`
  - `EXC_STORE_ACCESS_FAULT`
- One combinational sub-module, `lsu_align`. It takes size, unsigned, offset, store data and read data. It produces be, shifted wdata, extended load data and the misalign flag.

## Test plan
- LW `addr`=0x100, rdata=0x8000_00F0, rd=5, zero-wait bus: `dmem_addr_o`=0x100, `be`=1111; `rd_valid_o` 4 cycles after accept with rd=5, data 0x8000_00F0.
- LB `addr`=0x103, rdata=0x80FF_FFFF:
  - signed: data 0xFFFF_FF80.
  - LBU: data 0x0000_0080.
- SH `addr`=0x202, data 0x1234, 3-cycle grant delay: `be`=1100, wdata 0x1234_1234, `dmem_req_o` held 3 cycles, retire with rd=0.
- LW `addr`=0x101: no `dmem_req_o`; `rd_exception_o`=1, data 4.
- SW with `dmem_err_i`=1 on rvalid: `rd_exception_o`=1, data 7, rd=0.
- `flush_i` in `MEM_WAIT`, then rvalid 2 cycles later: no `rd_valid_o`; `ex_ready_o` rises the cycle after rvalid; a following NONE op retires normally.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared types and constants for the RV32 pipeline.
// Holds the datapath widths, the memory-op/size/state enums used by
// mem_stage and the mcause codes that mem_stage reports on rd_data_o.
package rv32_pkg;

  localparam int DATA_W        = 32;
  localparam int RF_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    MEM_RESP = 2'd3
  } mem_state_e;

  localparam logic [31:0] EXC_LOAD_MISALIGNED    = 32'd4;
  localparam logic [31:0] EXC_LOAD_ACCESS_FAULT  = 32'd5;
  localparam logic [31:0] EXC_STORE_MISALIGNED   = 32'd6;
  localparam logic [31:0] EXC_STORE_ACCESS_FAULT = 32'd7;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: combinational lane steering for the RV32 load/store unit.
// Inputs : size_i (mem_size_e), unsigned_i, offset_i (addr[1:0]),
//          store_data_i (LSB aligned), rdata_i (raw bus word).
// Outputs: be_o (byte enables), wdata_o (lane-replicated store data),
//          load_data_o (extracted and extended load value),
//          misaligned_o (access not naturally aligned).
module lsu_align
  import rv32_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [31:0] shifted;
  logic        sign_fill;

  always_comb begin
    be_o         = 4'b1111;
    wdata_o      = store_data_i;
    load_data_o  = rdata_i;
    misaligned_o = 1'b0;
    sign_fill    = 1'b0;
    // Bring the addressed lane down to bit 0 before extension.
    shifted      = rdata_i >> {offset_i, 3'b000};
    case (size_i)
      MEM_SIZE_BYTE: begin
        be_o        = 4'b0001 << offset_i;
        wdata_o     = {4{store_data_i[7:0]}};
        sign_fill   = ~unsigned_i & shifted[7];
        load_data_o = {{24{sign_fill}}, shifted[7:0]};
      end
      MEM_SIZE_HALF: begin
        be_o         = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{store_data_i[15:0]}};
        sign_fill    = ~unsigned_i & shifted[15];
        load_data_o  = {{16{sign_fill}}, shifted[15:0]};
        misaligned_o = offset_i[0];
      end
      default: begin
        misaligned_o = |offset_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and wb_stage.
// Ports:
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   ex_*                   - execute result offer (valid/ready handshake)
//   flush_i                - pipeline flush from wb_stage
//   dmem_*                 - request/grant/response data-bus port
//   rd_*                   - registered writeback result, rd_valid_o pulses
//   mem_stall_o            - stage busy (not idle)
// The datapath is RV32: lane logic assumes DATA_W = 32.
module mem_stage #(
  parameter int DATA_W        = rv32_pkg::DATA_W,
  parameter int RF_ADDR_WIDTH = rv32_pkg::RF_ADDR_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     ex_valid_i,
  output logic                     ex_ready_o,
  input  logic [DATA_W-1:0]        ex_alu_result_i,
  input  logic [DATA_W-1:0]        ex_store_data_i,
  input  logic [RF_ADDR_WIDTH-1:0] ex_rd_addr_i,
  input  logic                     ex_rd_we_i,
  input  logic [1:0]               ex_mem_op_i,
  input  logic [1:0]               ex_mem_size_i,
  input  logic                     ex_mem_unsigned_i,
  input  logic                     flush_i,
  output logic                     dmem_req_o,
  input  logic                     dmem_gnt_i,
  output logic [DATA_W-1:0]        dmem_addr_o,
  output logic                     dmem_we_o,
  output logic [3:0]               dmem_be_o,
  output logic [DATA_W-1:0]        dmem_wdata_o,
  input  logic                     dmem_rvalid_i,
  input  logic [DATA_W-1:0]        dmem_rdata_i,
  input  logic                     dmem_err_i,
  output logic [RF_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_valid_o,
  output logic                     rd_exception_o,
  output logic                     mem_stall_o
);
  import rv32_pkg::*;

  mem_state_e               state_q, state_d;
  logic                     drop_q, drop_d;
  logic [1:0]               op_q, op_d;
  logic [1:0]               size_q, size_d;
  logic                     uns_q, uns_d;
  logic [DATA_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        sdata_q, sdata_d;
  logic [RF_ADDR_WIDTH-1:0] dst_q, dst_d;
  logic                     we_q, we_d;
  logic                     rd_valid_q, rd_valid_d;
  logic [RF_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]        rd_data_q, rd_data_d;
  logic                     rd_exc_q, rd_exc_d;

  // A single aligner serves both the accept decision (fed from ex_* while
  // idle) and the bus phases (fed from the captured instruction).
  logic                     idle;
  logic [1:0]               al_size;
  logic                     al_uns;
  logic [DATA_W-1:0]        al_addr;
  logic [DATA_W-1:0]        al_sdata;
  logic [3:0]               al_be;
  logic [DATA_W-1:0]        al_wdata;
  logic [DATA_W-1:0]        al_load;
  logic                     al_mis;

  assign idle     = (state_q == MEM_IDLE);
  assign al_size  = idle ? ex_mem_size_i     : size_q;
  assign al_uns   = idle ? ex_mem_unsigned_i : uns_q;
  assign al_addr  = idle ? ex_alu_result_i   : addr_q;
  assign al_sdata = idle ? ex_store_data_i   : sdata_q;

  lsu_align u_lsu_align (
    .size_i       (al_size),
    .unsigned_i   (al_uns),
    .offset_i     (al_addr[1:0]),
    .store_data_i (al_sdata),
    .rdata_i      (dmem_rdata_i),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load),
    .misaligned_o (al_mis)
  );

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    op_d       = op_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    dst_d      = dst_q;
    we_d       = we_q;
    rd_valid_d = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    rd_exc_d   = rd_exc_q;
    case (state_q)
      MEM_IDLE: begin
        if (ex_valid_i && !flush_i) begin
          op_d    = ex_mem_op_i;
          size_d  = ex_mem_size_i;
          uns_d   = ex_mem_unsigned_i;
          addr_d  = ex_alu_result_i;
          sdata_d = ex_store_data_i;
          dst_d   = ex_rd_addr_i;
          we_d    = ex_rd_we_i;
          if (ex_mem_op_i != MEM_OP_LOAD && ex_mem_op_i != MEM_OP_STORE) begin
            state_d   = MEM_RESP;
            rd_data_d = ex_alu_result_i;
            rd_exc_d  = 1'b0;
            rd_addr_d = ex_rd_we_i ? ex_rd_addr_i : '0;
          end else if (al_mis) begin
            state_d   = MEM_RESP;
            rd_exc_d  = 1'b1;
            rd_addr_d = '0;
            rd_data_d = (ex_mem_op_i == MEM_OP_LOAD) ? DATA_W'(EXC_LOAD_MISALIGNED)
                                                     : DATA_W'(EXC_STORE_MISALIGNED);
          end else begin
            state_d = MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        // Grant beats a coincident flush; the transfer then runs as dropped.
        if (dmem_gnt_i) begin
          state_d = MEM_WAIT;
          drop_d  = flush_i;
        end else if (flush_i) begin
          state_d = MEM_IDLE;
        end
      end
      MEM_WAIT: begin
        if (dmem_rvalid_i) begin
          if (drop_q || flush_i) begin
            state_d = MEM_IDLE;
            drop_d  = 1'b0;
          end else begin
            state_d = MEM_RESP;
            if (dmem_err_i) begin
              rd_exc_d  = 1'b1;
              rd_addr_d = '0;
              rd_data_d = (op_q == MEM_OP_LOAD) ? DATA_W'(EXC_LOAD_ACCESS_FAULT)
                                                : DATA_W'(EXC_STORE_ACCESS_FAULT);
            end else if (op_q == MEM_OP_LOAD) begin
              rd_exc_d  = 1'b0;
              rd_addr_d = we_q ? dst_q : '0;
              rd_data_d = al_load;
            end else begin
              rd_exc_d  = 1'b0;
              rd_addr_d = '0;
              rd_data_d = '0;
            end
          end
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        rd_valid_d = !flush_i;
        state_d    = MEM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= MEM_IDLE;
      drop_q     <= 1'b0;
      op_q       <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      sdata_q    <= '0;
      dst_q      <= '0;
      we_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_exc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      op_q       <= op_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      dst_q      <= dst_d;
      we_q       <= we_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      rd_exc_q   <= rd_exc_d;
    end
  end

  assign ex_ready_o     = idle;
  assign mem_stall_o    = !idle;
  assign dmem_req_o     = (state_q == MEM_REQ);
  assign dmem_we_o      = dmem_req_o && (op_q == MEM_OP_STORE);
  assign dmem_be_o      = dmem_req_o ? al_be : 4'b0000;
  assign dmem_wdata_o   = dmem_req_o ? al_wdata : '0;
  assign dmem_addr_o    = {addr_q[DATA_W-1:2], 2'b00};
  assign rd_valid_o     = rd_valid_q;
  assign rd_addr_o      = rd_addr_q;
  assign rd_data_o      = rd_data_q;
  assign rd_exception_o = rd_exc_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [31:0] ex_alu_result_i;
  logic [31:0] ex_store_data_i;
  logic [4:0]  ex_rd_addr_i;
  logic        ex_rd_we_i;
  logic [1:0]  ex_mem_op_i;
  logic [1:0]  ex_mem_size_i;
  logic        ex_mem_unsigned_i;
  logic        flush_i;
  logic        dmem_req_o;
  logic        dmem_gnt_i;
  logic [31:0] dmem_addr_o;
  logic        dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        dmem_err_i;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        rd_exception_o;
  logic        mem_stall_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  mem_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_alu_result_i(ex_alu_result_i), .ex_store_data_i(ex_store_data_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_we_i(ex_rd_we_i),
    .ex_mem_op_i(ex_mem_op_i), .ex_mem_size_i(ex_mem_size_i),
    .ex_mem_unsigned_i(ex_mem_unsigned_i), .flush_i(flush_i),
    .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_addr_o(dmem_addr_o), .dmem_we_o(dmem_we_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .dmem_err_i(dmem_err_i),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .rd_exception_o(rd_exception_o),
    .mem_stall_o(mem_stall_o)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference: expected bus access and writeback result from the ISA-level
  // rules (natural alignment, lane = addr mod 4, sign extension by value).
  task automatic model(input int op, input int size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] rdata, input logic [4:0] rd,
                       input bit we, input bit err,
                       output bit bus, output logic [31:0] e_addr,
                       output logic [3:0] e_be, output logic [31:0] e_wdata,
                       output logic [31:0] e_data, output logic [4:0] e_rd,
                       output bit e_exc, output bit chk_data);
    int     nbytes;
    int     off;
    longint val;
    nbytes   = 1 << size;
    off      = int'(addr % 4);
    bus      = 0;
    e_addr   = addr & 32'hFFFF_FFFC;
    e_be     = 4'b0000;
    e_wdata  = 32'h0;
    e_data   = 32'h0;
    e_rd     = 5'd0;
    e_exc    = 0;
    chk_data = 1;
    if (op == 0) begin
      e_data = addr;
      e_rd   = we ? rd : 5'd0;
    end else if (off % nbytes != 0) begin
      e_exc  = 1;
      e_data = (op == 1) ? 32'd4 : 32'd6;
    end else begin
      bus  = 1;
      e_be = 4'(((1 << nbytes) - 1) << off);
      for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = sdata[8*(i % nbytes) +: 8];
      if (err) begin
        e_exc  = 1;
        e_data = (op == 1) ? 32'd5 : 32'd7;
      end else if (op == 1) begin
        val = longint'(rdata >> (8 * off)) & ((longint'(1) << (8 * nbytes)) - 1);
        if (!uns && nbytes < 4 && val >= (longint'(1) << (8 * nbytes - 1)))
          val = val - (longint'(1) << (8 * nbytes));
        e_data = val[31:0];
        e_rd   = we ? rd : 5'd0;
      end else begin
        chk_data = 0;
      end
    end
  endtask

  // One complete instruction: offer, act as the bus (grant after gd extra
  // cycles, response rvd extra cycles after grant), then check the retire.
  task automatic run_op(input string tag, input int op, input int size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input bit we, input int gd, input int rvd,
                        input bit err, input logic [31:0] rdata);
    bit          bus, e_exc, chk_data, got, granted, responded;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [3:0]  e_be;
    logic [4:0]  e_rd;
    int          cyc, req_cycles, wait_cyc, exp_lat;
    model(op, size, uns, addr, sdata, rdata, rd, we, err,
          bus, e_addr, e_be, e_wdata, e_data, e_rd, e_exc, chk_data);
    exp_lat = bus ? (4 + gd + rvd) : 2;
    @(negedge clk_i);
    check_val({tag, ".ex_ready"}, 32'(ex_ready_o), 32'd1);
    ex_valid_i        = 1'b1;
    ex_alu_result_i   = addr;
    ex_store_data_i   = sdata;
    ex_rd_addr_i      = rd;
    ex_rd_we_i        = we;
    ex_mem_op_i       = 2'(op);
    ex_mem_size_i     = 2'(size);
    ex_mem_unsigned_i = uns;
    @(posedge clk_i);
    #1 ex_valid_i = 1'b0;
    cyc = 0; req_cycles = 0; wait_cyc = 0;
    got = 0; granted = 0; responded = 0;
    while (!got && cyc < 64) begin
      @(negedge clk_i);
      cyc++;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0;
      if (cyc == 1) check_val({tag, ".stall"}, 32'(mem_stall_o), 32'd1);
      if (rd_valid_o) begin
        got = 1;
        check_val({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
        check_val({tag, ".rd_addr"}, 32'(rd_addr_o), 32'(e_rd));
        check_val({tag, ".exception"}, 32'(rd_exception_o), 32'(e_exc));
        if (chk_data) check_val({tag, ".rd_data"}, rd_data_o, e_data);
      end else if (dmem_req_o) begin
        if (req_cycles == 0 || req_cycles == gd) begin
          check_val({tag, ".dmem_addr"}, dmem_addr_o, e_addr);
          check_val({tag, ".dmem_be"}, 32'(dmem_be_o), 32'(e_be));
          check_val({tag, ".dmem_we"}, 32'(dmem_we_o), (op == 2) ? 32'd1 : 32'd0);
          if (op == 2) check_val({tag, ".dmem_wdata"}, dmem_wdata_o, e_wdata);
        end
        req_cycles++;
        if (req_cycles == gd + 1) begin
          dmem_gnt_i = 1'b1;
          granted    = 1;
        end
      end else if (granted && !responded) begin
        wait_cyc++;
        if (wait_cyc == rvd + 1) begin
          dmem_rvalid_i = 1'b1;
          dmem_rdata_i  = rdata;
          dmem_err_i    = err;
          responded     = 1;
        end
      end
    end
    if (!got) check_val({tag, ".retire_timeout"}, 32'd0, 32'd1);
    check_val({tag, ".req_cycles"}, 32'(req_cycles), bus ? 32'(gd + 1) : 32'd0);
    @(negedge clk_i);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0;
    check_val({tag, ".pulse"}, 32'(rd_valid_o), 32'd0);
    $display("txn %-10s op=%0d size=%0d uns=%0d addr=%08h rd=%0d gd=%0d rvd=%0d err=%0d -> exc=%0d data=%08h lat=%0d",
             tag, op, size, uns, addr, rd, gd, rvd, err, rd_exception_o, rd_data_o, cyc);
  endtask

  task automatic offer(input int op, input logic [31:0] addr);
    @(negedge clk_i);
    ex_valid_i      = 1'b1;
    ex_alu_result_i = addr;
    ex_mem_op_i     = 2'(op);
    ex_mem_size_i   = 2'd2;
    ex_rd_addr_i    = 5'd3;
    ex_rd_we_i      = 1'b1;
    @(posedge clk_i);
    #1 ex_valid_i = 1'b0;
  endtask

  initial begin
    int seen;
    rst_ni = 1'b0; ex_valid_i = 1'b0; ex_alu_result_i = '0; ex_store_data_i = '0;
    ex_rd_addr_i = '0; ex_rd_we_i = 1'b0; ex_mem_op_i = '0; ex_mem_size_i = '0;
    ex_mem_unsigned_i = 1'b0; flush_i = 1'b0; dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = '0; dmem_err_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_val("reset.rd_valid", 32'(rd_valid_o), 32'd0);
    check_val("reset.rd_data", rd_data_o, 32'd0);
    check_val("reset.dmem_req", 32'(dmem_req_o), 32'd0);
    check_val("reset.dmem_addr", dmem_addr_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_val("reset.ex_ready", 32'(ex_ready_o), 32'd1);
    check_val("reset.stall", 32'(mem_stall_o), 32'd0);

    // Directed cases.
    run_op("lw_zw",   1, 2, 0, 32'h100, 32'h0, 5'd5, 1, 0, 0, 0, 32'h8000_00F0);
    run_op("lb_s",    1, 0, 0, 32'h103, 32'h0, 5'd6, 1, 1, 1, 0, 32'h80FF_FFFF);
    run_op("lbu",     1, 0, 1, 32'h103, 32'h0, 5'd6, 1, 0, 2, 0, 32'h80FF_FFFF);
    run_op("sh",      2, 1, 0, 32'h202, 32'h1234, 5'd7, 1, 2, 0, 0, 32'h0);
    run_op("lw_mis",  1, 2, 0, 32'h101, 32'h0, 5'd8, 1, 0, 0, 0, 32'h0);
    run_op("sw_err",  2, 2, 0, 32'h300, 32'hCAFE_F00D, 5'd9, 1, 1, 1, 1, 32'h0);
    run_op("none",    0, 2, 0, 32'hDEAD_BEEF, 32'h0, 5'd10, 1, 0, 0, 0, 32'h0);

    // Flush while waiting for the response: no retire, ready after rvalid.
    offer(1, 32'h400);
    @(negedge clk_i); dmem_gnt_i = 1'b1;
    @(negedge clk_i); dmem_gnt_i = 1'b0; flush_i = 1'b1;
    @(negedge clk_i); flush_i = 1'b0;
    @(negedge clk_i); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_2222;
    check_val("flush_wait.busy", 32'(ex_ready_o), 32'd0);
    @(negedge clk_i); dmem_rvalid_i = 1'b0;
    check_val("flush_wait.ready", 32'(ex_ready_o), 32'd1);
    seen = int'(rd_valid_o);
    repeat (3) begin @(negedge clk_i); seen += int'(rd_valid_o); end
    check_val("flush_wait.no_retire", 32'(seen), 32'd0);
    run_op("after_fl", 0, 0, 0, 32'h0000_5A5A, 32'h0, 5'd11, 1, 0, 0, 0, 32'h0);

    // Flush before the grant drops the request.
    offer(2, 32'h500);
    @(negedge clk_i); flush_i = 1'b1;
    @(negedge clk_i); flush_i = 1'b0;
    check_val("flush_req.req", 32'(dmem_req_o), 32'd0);
    check_val("flush_req.ready", 32'(ex_ready_o), 32'd1);
    seen = int'(rd_valid_o);
    @(negedge clk_i); seen += int'(rd_valid_o);
    check_val("flush_req.no_retire", 32'(seen), 32'd0);

    // Flush in the response cycle suppresses the pulse.
    offer(0, 32'h600);
    @(negedge clk_i); flush_i = 1'b1;
    @(negedge clk_i); flush_i = 1'b0;
    seen = int'(rd_valid_o);
    @(negedge clk_i); seen += int'(rd_valid_o);
    check_val("flush_resp.no_retire", 32'(seen), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      int op, size;
      op   = int'($urandom_range(0, 2));
      size = int'($urandom_range(0, 2));
      run_op("rand", op, size, 1'($urandom), (op == 0) ? $urandom : ($urandom & 32'hFFF),
             $urandom, 5'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
